// File: rtl/operand_queue_array.sv
// Generic circular buffer with registered storage and an occupancy count.
// Latency: a word pushed in cycle N is readable on rdata in cycle N+1; no fall-through.
// Backpressure: a push into a full buffer is dropped unless a pop happens in the same cycle.
module fifo #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push,
    input  logic [Width-1:0]           wdata,
    input  logic                       pop,
    output logic [Width-1:0]           rdata,
    output logic [$clog2(Depth+1)-1:0] count
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wptr;
    logic [PtrW-1:0]  rptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FullCnt);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty & ~flush_i;
    assign do_push = push & (~full | do_pop) & ~flush_i;
    assign rdata   = mem[rptr];

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; flush returns to the empty state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= (wptr == LastPtr) ? '0 : wptr + PtrW'(1);
            end
            if (do_pop) begin
                rptr <= (rptr == LastPtr) ? '0 : rptr + PtrW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CntW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CntW'(1);
            end
        end
    end

    // A push into a full buffer without a same-cycle pop silently loses the word.
    assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
        !(push && full && !pop));

endmodule

// Bank of independent operand queues: per channel a data FIFO, a command FIFO, credits and a beat counter.
// Latency: VRF data written in cycle N appears on operand_o in cycle N+1 when a command is active.
// Backpressure: operand_ready_i stalls the head beat; credits bound outstanding VRF reads to the buffer depth.
module operand_queue_array #(
    parameter int NrQueues     = 4,
    parameter int DataWidth    = 64,
    parameter int DataBufDepth = 4,
    parameter int CmdBufDepth  = 4,
    parameter int CntWidth     = 16
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      flush_i,
    input  logic [NrQueues*CntWidth-1:0]              cmd_cnt_i,
    input  logic [NrQueues-1:0]                       cmd_valid_i,
    output logic [NrQueues-1:0]                       cmd_ready_o,
    input  logic [NrQueues*DataWidth-1:0]             operand_i,
    input  logic [NrQueues-1:0]                       operand_valid_i,
    input  logic [NrQueues-1:0]                       operand_issued_i,
    output logic [NrQueues-1:0]                       operand_queue_ready_o,
    output logic [NrQueues*DataWidth-1:0]             operand_o,
    output logic [NrQueues-1:0]                       operand_valid_o,
    output logic [NrQueues-1:0]                       operand_last_o,
    input  logic [NrQueues-1:0]                       operand_ready_i,
    output logic [NrQueues*$clog2(DataBufDepth+1)-1:0] occupancy_o
);
    localparam int OccW    = $clog2(DataBufDepth + 1);
    localparam int CmdCntW = $clog2(CmdBufDepth + 1);
    localparam logic [OccW-1:0]     CreditMax = OccW'(DataBufDepth);
    localparam logic [CmdCntW-1:0]  CmdFull   = CmdCntW'(CmdBufDepth);
    localparam logic [CmdCntW-1:0]  CmdOne    = CmdCntW'(1);
    localparam logic [CntWidth-1:0] CntOne    = CntWidth'(1);

    // Idle: no command; Load: head command's count is used directly; Stream: count lives in rem_q.
    typedef enum logic [1:0] {
        Idle   = 2'd0,
        Load   = 2'd1,
        Stream = 2'd2
    } state_e;

    for (genvar q = 0; q < NrQueues; q++) begin : g_ch
        state_e               state_q;
        state_e               state_d;
        logic [CntWidth-1:0]  rem_q;
        logic [CntWidth-1:0]  rem_d;
        logic [CntWidth-1:0]  rem_eff;
        logic [CntWidth-1:0]  cmd_head;
        logic [CmdCntW-1:0]   cmd_count;
        logic [OccW-1:0]      data_count;
        logic [DataWidth-1:0] data_head;
        logic [OccW-1:0]      credit_q;
        logic                 cmd_rdy;
        logic                 cmd_push;
        logic                 cmd_pop;
        logic                 cmd_more;
        logic                 out_vld;
        logic                 beat;
        logic                 issue;

        assign cmd_rdy  = (cmd_count != CmdFull);
        assign cmd_push = cmd_valid_i[q] & cmd_rdy;
        assign cmd_more = (cmd_count > CmdOne);
        assign issue    = operand_issued_i[q];

        fifo #(
            .Width (CntWidth),
            .Depth (CmdBufDepth)
        ) i_cmd_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .flush_i (flush_i),
            .push    (cmd_push),
            .wdata   (cmd_cnt_i[q*CntWidth +: CntWidth]),
            .pop     (cmd_pop),
            .rdata   (cmd_head),
            .count   (cmd_count)
        );

        fifo #(
            .Width (DataWidth),
            .Depth (DataBufDepth)
        ) i_data_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .flush_i (flush_i),
            .push    (operand_valid_i[q]),
            .wdata   (operand_i[q*DataWidth +: DataWidth]),
            .pop     (beat),
            .rdata   (data_head),
            .count   (data_count)
        );

        // In Load the head count is consumed in place so a retiring command hands over without a bubble.
        assign rem_eff = (state_q == Load) ? cmd_head : rem_q;
        assign out_vld = (state_q != Idle) && (rem_eff != '0) && (data_count != '0);
        assign beat    = out_vld & operand_ready_i[q] & ~flush_i;

        // Next-state and beat-count logic; the command is popped on its last beat or at once if empty.
        always_comb begin
            state_d = state_q;
            rem_d   = rem_q;
            cmd_pop = 1'b0;
            case (state_q)
                Idle: begin
                    if (cmd_count != '0) begin
                        state_d = Load;
                    end
                end
                Load: begin
                    if ((cmd_head == '0) || (beat && (cmd_head == CntOne))) begin
                        cmd_pop = 1'b1;
                        rem_d   = '0;
                        state_d = cmd_more ? Load : Idle;
                    end else begin
                        rem_d   = cmd_head - (beat ? CntOne : '0);
                        state_d = Stream;
                    end
                end
                Stream: begin
                    if (beat) begin
                        rem_d = rem_q - CntOne;
                        if (rem_q == CntOne) begin
                            cmd_pop = 1'b1;
                            state_d = cmd_more ? Load : Idle;
                        end
                    end
                end
                default: begin
                    state_d = Idle;
                    rem_d   = '0;
                end
            endcase
        end

        // State, beat counter and credit registers; flush behaves like reset at the edge.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q  <= Idle;
                rem_q    <= '0;
                credit_q <= CreditMax;
            end else if (flush_i) begin
                state_q  <= Idle;
                rem_q    <= '0;
                credit_q <= CreditMax;
            end else begin
                state_q <= state_d;
                rem_q   <= rem_d;
                if (issue && !beat) begin
                    if (credit_q != '0) begin
                        credit_q <= credit_q - OccW'(1);
                    end
                end else if (beat && !issue) begin
                    if (credit_q != CreditMax) begin
                        credit_q <= credit_q + OccW'(1);
                    end
                end
            end
        end

        // Requester must not issue a read without a free buffer slot.
        assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
            !(issue && (credit_q == '0)));

        // Returning more credits than buffer entries means a beat was never issued.
        assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
            !(beat && !issue && (credit_q == CreditMax)));

        assign cmd_ready_o[q]                       = cmd_rdy;
        assign operand_queue_ready_o[q]             = (credit_q != '0);
        assign operand_valid_o[q]                   = out_vld;
        assign operand_last_o[q]                    = out_vld & (rem_eff == CntOne);
        assign operand_o[q*DataWidth +: DataWidth]  = out_vld ? data_head : '0;
        assign occupancy_o[q*OccW +: OccW]          = data_count;
    end

endmodule

// File: doc/operand_queue_array.md
Name: operand_queue_array

Overview:
- Parametrised bank of NrQueues independent operand queues between the VRF/operand requester and the VFUs.
- Generalises the single fixed-configuration operand queue in three ways:
  - configurable channel count and data width;
  - credit-based issue control;
  - command-driven beat counting with last-beat marking.
- Also adds a synchronous flush for exception/kill handling.
- Each channel buffers VRF read data and releases it to its consumer under a valid/ready handshake, bounded by the beat count of the active command.

Parameters:
- NrQueues, 4, number of independent channels.
- DataWidth, 64, operand word width in bits.
- DataBufDepth, 4, data FIFO entries per channel (>=1).
- CmdBufDepth, 4, command FIFO entries per channel (>=1).
- CntWidth, 16, width of the per-command beat count.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- flush_i  in  1  synchronous clear of all channels.
- cmd_cnt_i  in  NrQueues*CntWidth  beats per command, per channel.
- cmd_valid_i  in  NrQueues  command push request.
- cmd_ready_o  out  NrQueues  command FIFO not full.
- operand_i  in  NrQueues*DataWidth  VRF read data.
- operand_valid_i  in  NrQueues  VRF data write strobe.
- operand_issued_i  in  NrQueues  requester issued one VRF read (consumes one credit).
- operand_queue_ready_o  out  NrQueues  credit available.
- operand_o  out  NrQueues*DataWidth  head data word.
- operand_valid_o  out  NrQueues  head beat valid.
- operand_last_o  out  NrQueues  head beat is the last beat of the active command.
- operand_ready_i  in  NrQueues  consumer accepts the beat.
- occupancy_o  out  NrQueues*$clog2(DataBufDepth+1)  data FIFO fill level.

Behaviour:
- Reset (rst_i high, asynchronous):
  - all FIFOs empty; credit counters = DataBufDepth; remaining-beat counters = 0.
  - outputs: operand_valid_o=0, operand_last_o=0, occupancy_o=0, cmd_ready_o=all 1, operand_queue_ready_o=all 1, operand_o=0.
- Reset asserted mid-transfer discards all buffered data and commands with no partial beats emitted. Channels operate independently; no cross-channel coupling except flush_i and reset.
- Credits:
  - issued without pop: credit -1. Pop without issued: +1. Both in the same cycle: unchanged.
  - operand_queue_ready_o = (credit != 0).
  - issued while credit==0 is a protocol violation: assertion fires, counter holds at 0.
- Data write:
  - operand_valid_i pushes operand_i into the data FIFO.
  - Push while full is an assertion error; the write is dropped.
  - No fall-through: a word written in cycle N is first visible on operand_o in cycle N+1.
  - Simultaneous push and pop on a full FIFO is legal.
- Command FIFO:
  - push when cmd_valid_i & cmd_ready_o.
  - Loading a head command sets remaining = cmd_cnt. The load happens in the cycle after the command reaches the head, or in the same cycle the previous command retires, with a back-to-back handoff and no bubble.
- Output:
  - operand_valid_o = active command & remaining!=0 & data FIFO non-empty.
  - operand_last_o = operand_valid_o & remaining==1.
  - A beat completes on operand_valid_o & operand_ready_i: pop data, remaining -1, credit +1.
  - When the last beat completes, pop the command.
- Zero-count command: retired in one cycle with no beat and no data pop.
- Data present with no active command: held, not emitted.
- Per-channel state machine:
  - IDLE (no command) -> LOAD when command FIFO non-empty.
  - LOAD -> STREAM when cnt!=0; LOAD -> IDLE, or LOAD again, when cnt==0.
  - STREAM -> LOAD or IDLE on the last beat, depending on command FIFO occupancy.
  - operand_o holds its value while valid & !ready.
- Flush:
  - flush_i high clears FIFOs, counters and state to reset values at the clock edge.
  - All inputs sampled in that cycle are ignored.
  - Outputs are at reset values in the following cycle.
- Width rules:
  - remaining counter is CntWidth bits, no wrap: decrement only when non-zero.
  - credit counter is $clog2(DataBufDepth+1) bits, saturating at DataBufDepth; incrementing past DataBufDepth is an assertion error.

Test Plan:
- Basic stream (NrQueues=4, DataBufDepth=4), channel 0:
  - push cmd cnt=3; issue 3 reads; write 0xA1,0xA2,0xA3 one per cycle; ready_i=1.
  - Required: beats A1,A2,A3 on cycles +1 after each write; last_o only with A3; credits return to 4.
- Back-pressure on channel 1, cnt=6, ready_i=0:
  - after 4 issues, operand_queue_ready_o=0 and occupancy_o=4.
  - raising ready_i drains one beat per cycle; ready_o re-asserts the cycle after the first pop.
  - no data loss; last_o on the 6th beat.
- Back-to-back commands on channel 2 (cnt=2 then cnt=1), data preloaded:
  - 3 consecutive beats with no bubble; last_o on beats 2 and 3; both command FIFO entries consumed.
- Zero-count command on channel 3, then cnt=1 with data 0x55:
  - cnt=0 produces no beat; 0x55 emitted with last_o.
- Simultaneous issue and pop at credit=1 on channel 0: credit stays 1; ready_o stays high.
- Flush and reset mid-operation:
  - flush_i with 3 words buffered: next cycle occupancy_o=0, valid_o=0, credits=4, cmd_ready_o=1.
  - asserting rst_i asynchronously mid-beat immediately forces valid_o=0.
